// File: rtl/microwave_timer.sv
// ---------------------------------------------------------------------------
// microwave_timer
//   Time-entry and countdown stage fed by the keypad encoder. Digits are
//   shifted into an M:SS register and counted down to 0:00 once started.
//
// Ports
//   clk          in   system clock, rising edge
//   clearn       in   asynchronous active-low reset
//   data[3:0]    in   BCD digit, valid while loadn is low
//   loadn        in   active-low digit strobe
//   startn       in   active-low start/resume button
//   stopn        in   active-low stop/clear button
//   door_closed  in   1 = door closed, cooking permitted
//   min_ones     out  BCD minutes digit
//   sec_tens     out  BCD tens-of-seconds digit
//   sec_ones     out  BCD seconds digit
//   zero         out  all three digits are 0
//   running      out  high in RUNNING (magnetron enable)
//   done         out  one-cycle pulse when the countdown reaches 0:00
//   dbg_state    out  current FSM state (0 ENTRY, 1 RUNNING, 2 PAUSED)
//
// Handshake: there is no valid/ready pair here. Each active-low strobe is
// turned into a single-cycle press pulse on its falling edge; that pulse is
// registered and acted on at the following clock edge, so holding a button
// acts exactly once.
// ---------------------------------------------------------------------------
module microwave_timer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] data,
    input  logic       loadn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       running,
    output logic       done,
    output logic [1:0] dbg_state
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_e;

    // Registered copies of the raw strobes and the resulting press pulses.
    logic          loadn_q, startn_q, stopn_q;
    logic          load_p_q, start_p_q, stop_p_q;
    logic [3:0]    data_q;

    state_e        state_q, state_d;
    logic [3:0]    min_q, min_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          zero_q, running_q, done_q, done_d;

    logic [3:0]    dec_min, dec_tens, dec_ones;

    // One-second decrement of the M:SS value with borrow into the next digit.
    always_comb begin
        dec_min  = min_q;
        dec_tens = tens_q;
        dec_ones = ones_q;
        if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
        end else begin
            dec_ones = 4'd9;
            if (tens_q != 4'd0) begin
                dec_tens = tens_q - 4'd1;
            end else begin
                dec_tens = 4'd5;
                dec_min  = min_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                if (stop_p_q) begin
                    min_d  = 4'd0;
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                end else if (start_p_q) begin
                    if (door_closed && !zero_q) begin
                        state_d = ST_RUNNING;
                        presc_d = '0;
                    end
                end else if (load_p_q && (data_q <= 4'd9)) begin
                    min_d  = tens_q;
                    tens_d = ones_q;
                    ones_d = data_q;
                end
            end
            ST_RUNNING: begin
                // Pausing takes precedence over a coincident terminal tick.
                if (stop_p_q || !door_closed) begin
                    state_d = ST_PAUSED;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    min_d   = dec_min;
                    tens_d  = dec_tens;
                    ones_d  = dec_ones;
                    if (dec_min == 4'd0 && dec_tens == 4'd0 && dec_ones == 4'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_ENTRY;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_PAUSED: begin
                if (stop_p_q) begin
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    presc_d = '0;
                    state_d = ST_ENTRY;
                end else if (start_p_q && door_closed) begin
                    state_d = ST_RUNNING;
                end
            end
            default: begin
                state_d = ST_ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            loadn_q   <= 1'b1;
            startn_q  <= 1'b1;
            stopn_q   <= 1'b1;
            load_p_q  <= 1'b0;
            start_p_q <= 1'b0;
            stop_p_q  <= 1'b0;
            data_q    <= 4'd0;
            state_q   <= ST_ENTRY;
            min_q     <= 4'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            presc_q   <= '0;
            zero_q    <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            loadn_q   <= loadn;
            startn_q  <= startn;
            stopn_q   <= stopn;
            load_p_q  <= ~loadn & loadn_q;
            start_p_q <= ~startn & startn_q;
            stop_p_q  <= ~stopn & stopn_q;
            // Capture the digit with its strobe so it is stable when used.
            if (~loadn & loadn_q) begin
                data_q <= data;
            end
            state_q   <= state_d;
            min_q     <= min_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            presc_q   <= presc_d;
            zero_q    <= (min_d == 4'd0) && (tens_d == 4'd0) && (ones_d == 4'd0);
            running_q <= (state_d == ST_RUNNING);
            done_q    <= done_d;
        end
    end

    assign min_ones  = min_q;
    assign sec_tens  = tens_q;
    assign sec_ones  = ones_q;
    assign zero      = zero_q;
    assign running   = running_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_microwave_timer.sv
// ---------------------------------------------------------------------------
// tb_microwave_timer
//   Self-checking bench for microwave_timer with TICKS_PER_SEC = 4.
//   Expected output vectors {state, M, S10, S1, zero, running, done} are
//   pushed to exp_q when stimulus is applied and popped when compared.
// ---------------------------------------------------------------------------
module tb_microwave_timer;

    localparam logic [1:0] S_ENTRY   = 2'd0;
    localparam logic [1:0] S_RUNNING = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;

    // Clock / reset
    logic       clk = 1'b0;
    logic       clearn = 1'b1;
    logic [3:0] data = 4'd0;
    logic       loadn = 1'b1;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       door_closed = 1'b1;
    logic [3:0] min_ones, sec_tens, sec_ones;
    logic       zero, running, done;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    microwave_timer #(.TICKS_PER_SEC(4)) dut (
        .clk         (clk),
        .clearn      (clearn),
        .data        (data),
        .loadn       (loadn),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .zero        (zero),
        .running     (running),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // Scoreboard
    logic [16:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [16:0] mk(logic [1:0] st, logic [3:0] m, logic [3:0] t,
                                       logic [3:0] o, logic run, logic dn);
        logic z;
        z = (m == 4'd0) && (t == 4'd0) && (o == 4'd0);
        return {st, m, t, o, z, run, dn};
    endfunction

    task automatic cmp(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%0d %h:%h%h z=%b run=%b done=%b, expected st=%0d %h:%h%h z=%b run=%b done=%b",
                     name, act[16:15], act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                     exp[16:15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_out(input string name);
        logic [16:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            cmp(name, {dbg_state, min_ones, sec_tens, sec_ones, zero, running, done}, e);
        end
    endtask

    task automatic expect_now(input string name, input logic [16:0] e);
        exp_q.push_back(e);
        check_out(name);
    endtask

    // Driver tasks: inputs change 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_load(input logic [3:0] d, input int hold);
        data  = d;
        loadn = 1'b0;
        step(hold);
        loadn = 1'b1;
    endtask

    task automatic press_start();
        startn = 1'b0;
        step(1);
        startn = 1'b1;
    endtask

    task automatic press_stop();
        stopn = 1'b0;
        step(1);
        stopn = 1'b1;
    endtask

    // Digit entry table
    typedef struct {
        logic [3:0] d;
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{d: 4'd1,  m: 4'd0, t: 4'd0, o: 4'd1};
        tbl[1] = '{d: 4'd2,  m: 4'd0, t: 4'd1, o: 4'd2};
        tbl[2] = '{d: 4'd3,  m: 4'd1, t: 4'd2, o: 4'd3};
        tbl[3] = '{d: 4'd4,  m: 4'd2, t: 4'd3, o: 4'd4};
        tbl[4] = '{d: 4'd12, m: 4'd2, t: 4'd3, o: 4'd4};

        // Reset state
        #1 clearn = 1'b0;
        step(2);
        expect_now("reset_state", mk(S_ENTRY, 0, 0, 0, 0, 0));
        clearn = 1'b1;
        step(1);

        // Digit entry with held strobes and an out-of-range digit
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mk(S_ENTRY, tbl[i].m, tbl[i].t, tbl[i].o, 0, 0));
            press_load(tbl[i].d, 3);
            step(1);
            check_out($sformatf("entry_%0d", i));
        end

        // Stop in ENTRY clears
        press_stop();
        step(1);
        expect_now("entry_stop_clear", mk(S_ENTRY, 0, 0, 0, 0, 0));

        // Countdown from 1:00
        press_load(4'd1, 1); step(1);
        press_load(4'd0, 1); step(1);
        press_load(4'd0, 1); step(1);
        expect_now("cd_entered", mk(S_ENTRY, 1, 0, 0, 0, 0));
        press_start();
        step(1);
        expect_now("cd_running", mk(S_RUNNING, 1, 0, 0, 1, 0));
        step(4);
        expect_now("cd_first_dec", mk(S_RUNNING, 0, 5, 9, 1, 0));
        step(235);
        expect_now("cd_one_left", mk(S_RUNNING, 0, 0, 1, 1, 0));
        step(1);
        expect_now("cd_done", mk(S_ENTRY, 0, 0, 0, 0, 1));
        step(1);
        expect_now("cd_done_drop", mk(S_ENTRY, 0, 0, 0, 0, 0));

        // Pause on door open, resume on start
        press_load(4'd0, 1); step(1);
        press_load(4'd5, 1); step(1);
        press_start();
        step(1);
        expect_now("pr_running", mk(S_RUNNING, 0, 0, 5, 1, 0));
        step(2);
        door_closed = 1'b0;
        step(1);
        expect_now("pr_door_pause", mk(S_PAUSED, 0, 0, 5, 0, 0));
        door_closed = 1'b1;
        step(3);
        expect_now("pr_no_autoresume", mk(S_PAUSED, 0, 0, 5, 0, 0));
        press_start();
        step(1);
        expect_now("pr_resumed", mk(S_RUNNING, 0, 0, 5, 1, 0));
        step(1);
        expect_now("pr_resume_hold", mk(S_RUNNING, 0, 0, 5, 1, 0));
        step(1);
        expect_now("pr_resume_dec", mk(S_RUNNING, 0, 0, 4, 1, 0));
        press_stop();
        step(1);
        expect_now("pr_stop_pause", mk(S_PAUSED, 0, 0, 4, 0, 0));
        press_stop();
        step(1);
        expect_now("pr_stop_clear", mk(S_ENTRY, 0, 0, 0, 0, 0));

        // Stop behaviour at 0:30
        press_load(4'd3, 1); step(1);
        press_load(4'd0, 1); step(1);
        press_start();
        step(1);
        expect_now("st_running", mk(S_RUNNING, 0, 3, 0, 1, 0));
        press_stop();
        step(1);
        expect_now("st_paused", mk(S_PAUSED, 0, 3, 0, 0, 0));
        press_stop();
        step(1);
        expect_now("st_cleared", mk(S_ENTRY, 0, 0, 0, 0, 0));

        // Guards
        press_start();
        step(2);
        expect_now("gd_start_at_zero", mk(S_ENTRY, 0, 0, 0, 0, 0));
        press_load(4'd1, 1); step(1);
        press_load(4'd0, 1); step(1);
        door_closed = 1'b0;
        press_start();
        step(2);
        expect_now("gd_start_door_open", mk(S_ENTRY, 0, 1, 0, 0, 0));
        door_closed = 1'b1;
        step(1);
        press_start();
        step(1);
        expect_now("gd_running", mk(S_RUNNING, 0, 1, 0, 1, 0));
        press_load(4'd7, 1);
        step(1);
        expect_now("gd_load_ignored", mk(S_RUNNING, 0, 1, 0, 1, 0));
        step(2);
        expect_now("gd_borrow_dec", mk(S_RUNNING, 0, 0, 9, 1, 0));
        press_stop();
        step(1);
        press_stop();
        step(1);
        expect_now("gd_cleared", mk(S_ENTRY, 0, 0, 0, 0, 0));

        // Asynchronous reset mid-count at 0:42
        press_load(4'd4, 1); step(1);
        press_load(4'd2, 1); step(1);
        press_start();
        step(1);
        expect_now("rs_running", mk(S_RUNNING, 0, 4, 2, 1, 0));
        step(2);
        clearn = 1'b0;
        #2;
        expect_now("rs_async_reset", mk(S_ENTRY, 0, 0, 0, 0, 0));
        clearn = 1'b1;
        step(3);
        expect_now("rs_after_reset", mk(S_ENTRY, 0, 0, 0, 0, 0));

        // Exactly one done pulse over the whole run
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL done_pulse_count: got %0d expected 1", done_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
